// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared op codes, FSM encoding and strobe helpers for z80_bus_master
package z80_bus_pkg;

    localparam logic [2:0] OP_MEM_RD = 3'd0;
    localparam logic [2:0] OP_MEM_WR = 3'd1;
    localparam logic [2:0] OP_IO_RD  = 3'd2;
    localparam logic [2:0] OP_IO_WR  = 3'd3;
    localparam logic [2:0] OP_FETCH  = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3,
        S_HALTED,
        S_IA1,
        S_IA2,
        S_IAW,
        S_IA3
    } state_t;

    // Strobe vector ordering: {mrq_n, ior_n, crd_n, cm1_n, hlt_n}
    localparam logic [4:0] STROBE_IDLE = 5'b11111;
    localparam logic [4:0] STROBE_IACK = 5'b10101;
    localparam logic [4:0] STROBE_HALT = 5'b11110;

    function automatic logic op_is_io(input logic [2:0] op);
        return (op == OP_IO_RD) || (op == OP_IO_WR);
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return (op == OP_MEM_RD) || (op == OP_IO_RD) || (op == OP_FETCH);
    endfunction

    // Active strobes for a normal memory/IO/fetch cycle
    function automatic logic [4:0] bus_strobes(input logic [2:0] op);
        return {op_is_io(op), !op_is_io(op), !op_is_read(op), op != OP_FETCH, 1'b1};
    endfunction

endpackage

// File: rtl/z80_wait_timer.sv
// rtl/z80_wait_timer.sv - loadable 3-bit wait-state down-counter with hold and done flag
module z80_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       done
);

    logic [2:0] count;

    // Load takes priority; otherwise count down to zero unless held
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign done = (count == 3'd0);

endmodule

// File: rtl/z80_bus_master.sv
// rtl/z80_bus_master.sv - Z80-side bus initiator; optional Z80_BUS_IRQ_EN enables interrupt ack after any cycle
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        pm1,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_irq,
    output logic [15:0] ca,
    output logic [7:0]  cdo,
    input  logic [7:0]  cdi,
    output logic        mrq_n,
    output logic        ior_n,
    output logic        crd_n,
    output logic        cm1_n,
    output logic        hlt_n,
    input  logic        intb_n
);

    localparam logic [2:0] MEM_W = 3'(MEM_WAIT);
    localparam logic [2:0] IO_W  = 3'(IO_WAIT);

    state_t      state, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] ca_d;
    logic [7:0]  cdo_d;
    logic [4:0]  strb, strb_d;
    logic        rsp_valid_d, rsp_irq_d;
    logic [7:0]  rsp_rdata_d;
    logic        tmr_load, tmr_done;
    logic [2:0]  tmr_val;
    logic [2:0]  cyc_wait;

    assign cmd_ready = (state == S_IDLE) && pm1 && !rin;
    assign cyc_wait  = op_is_io(op_q) ? IO_W : MEM_W;

    assign {mrq_n, ior_n, crd_n, cm1_n, hlt_n} = strb;

    z80_wait_timer u_wait (
        .clk      (mck),
        .rst      (rin),
        .hold     (!pm1),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State and bus output registers; reset aborts any cycle in flight
    always_ff @(posedge mck) begin
        if (rin) begin
            state     <= S_IDLE;
            op_q      <= 3'd0;
            ca        <= 16'h0000;
            cdo       <= 8'h00;
            strb      <= STROBE_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_irq   <= 1'b0;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            ca        <= ca_d;
            cdo       <= cdo_d;
            strb      <= strb_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_irq   <= rsp_irq_d;
        end
    end

    // Next-state and next-output logic; pm1 low freezes everything except HALTED
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        ca_d        = ca;
        cdo_d       = cdo;
        strb_d      = strb;
        rsp_valid_d = 1'b0;
        rsp_irq_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        tmr_load    = 1'b0;
        tmr_val     = 3'd0;

        unique case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ca_d  = cmd_addr;
                    cdo_d = cmd_wdata;
                    op_d  = cmd_op;
                    if (cmd_op > OP_HALT) begin
                        // Reserved op: answer immediately, no bus activity
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_T1;
                    end
                end
            end
            S_T1: begin
                if (pm1) begin
                    if (op_q == OP_HALT) begin
                        ca_d    = {cdo, 8'h00};
                        strb_d  = STROBE_HALT;
                        state_d = S_HALTED;
                    end else begin
                        strb_d  = bus_strobes(op_q);
                        state_d = S_T2;
                    end
                end
            end
            S_T2: begin
                if (pm1) begin
                    if (cyc_wait != 3'd0) begin
                        tmr_load = 1'b1;
                        tmr_val  = cyc_wait - 3'd1;
                        state_d  = S_TW;
                    end else begin
                        state_d = S_T3;
                    end
                end
            end
            S_TW: begin
                if (pm1 && tmr_done) begin
                    state_d = S_T3;
                end
            end
            S_T3: begin
                if (pm1) begin
                    strb_d      = STROBE_IDLE;
                    rsp_valid_d = 1'b1;
                    if (op_is_read(op_q)) begin
                        rsp_rdata_d = cdi;
                    end
`ifdef Z80_BUS_IRQ_EN
                    state_d = intb_n ? S_IDLE : S_IA1;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_HALTED: begin
                if (!intb_n) begin
                    strb_d  = STROBE_IDLE;
                    state_d = S_IA1;
                end
            end
            S_IA1: begin
                if (pm1) begin
                    strb_d  = STROBE_IACK;
                    state_d = S_IA2;
                end
            end
            S_IA2: begin
                if (pm1) begin
                    if (IO_W != 3'd0) begin
                        tmr_load = 1'b1;
                        tmr_val  = IO_W - 3'd1;
                        state_d  = S_IAW;
                    end else begin
                        state_d = S_IA3;
                    end
                end
            end
            S_IAW: begin
                if (pm1 && tmr_done) begin
                    state_d = S_IA3;
                end
            end
            S_IA3: begin
                if (pm1) begin
                    strb_d      = STROBE_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_irq_d   = 1'b1;
                    rsp_rdata_d = cdi;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                strb_d  = STROBE_IDLE;
            end
        endcase
    end

endmodule
